// File: rtl/riscv_ex_pkg.sv
// Shared definitions for the execute stage: funct codes, FSM states and
// the mul/div operand decode.
package riscv_ex_pkg;

    localparam int EX_FUNCT_W = 5;

    // Integer ALU functs
    localparam logic [EX_FUNCT_W-1:0] EX_ADD    = 5'd0;
    localparam logic [EX_FUNCT_W-1:0] EX_SUB    = 5'd1;
    localparam logic [EX_FUNCT_W-1:0] EX_OR     = 5'd2;
    localparam logic [EX_FUNCT_W-1:0] EX_XOR    = 5'd3;
    localparam logic [EX_FUNCT_W-1:0] EX_AND    = 5'd4;
    localparam logic [EX_FUNCT_W-1:0] EX_SLT    = 5'd5;
    localparam logic [EX_FUNCT_W-1:0] EX_SLTU   = 5'd6;
    localparam logic [EX_FUNCT_W-1:0] EX_SLL    = 5'd7;
    localparam logic [EX_FUNCT_W-1:0] EX_SRL    = 5'd8;
    localparam logic [EX_FUNCT_W-1:0] EX_SRA    = 5'd9;

    // M-extension functs occupy 16..23 so a two-bit compare identifies them
    localparam logic [EX_FUNCT_W-1:0] EX_MUL    = 5'd16;
    localparam logic [EX_FUNCT_W-1:0] EX_MULH   = 5'd17;
    localparam logic [EX_FUNCT_W-1:0] EX_MULHSU = 5'd18;
    localparam logic [EX_FUNCT_W-1:0] EX_MULHU  = 5'd19;
    localparam logic [EX_FUNCT_W-1:0] EX_DIV    = 5'd20;
    localparam logic [EX_FUNCT_W-1:0] EX_DIVU   = 5'd21;
    localparam logic [EX_FUNCT_W-1:0] EX_REM    = 5'd22;
    localparam logic [EX_FUNCT_W-1:0] EX_REMU   = 5'd23;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_t;

    // Per-op attributes of a mul/div funct
    typedef struct packed {
        logic s1_signed;  // op1 treated as signed
        logic s2_signed;  // op2 treated as signed
        logic is_div;     // divide family (else multiply)
        logic hi;         // multiply returns upper half
        logic rem;        // divide returns remainder
    } md_dec_t;

    function automatic logic ex_is_muldiv(input logic [EX_FUNCT_W-1:0] f);
        return f[4:3] == 2'b10;
    endfunction

    function automatic md_dec_t md_decode(input logic [EX_FUNCT_W-1:0] f);
        md_dec_t d;
        d = '0;
        case (f)
            EX_MUL:    begin d.s1_signed = 1'b1; d.s2_signed = 1'b1; end
            EX_MULH:   begin d.s1_signed = 1'b1; d.s2_signed = 1'b1; d.hi = 1'b1; end
            EX_MULHSU: begin d.s1_signed = 1'b1; d.hi = 1'b1; end
            EX_MULHU:  begin d.hi = 1'b1; end
            EX_DIV:    begin d.s1_signed = 1'b1; d.s2_signed = 1'b1; d.is_div = 1'b1; end
            EX_DIVU:   begin d.is_div = 1'b1; end
            EX_REM:    begin d.s1_signed = 1'b1; d.s2_signed = 1'b1; d.is_div = 1'b1; d.rem = 1'b1; end
            EX_REMU:   begin d.is_div = 1'b1; d.rem = 1'b1; end
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Iterative multiply / restoring divide. Operands are reduced to magnitudes
// on start, one bit is processed per step, and signs are restored on the
// way out. Divide-by-zero and signed overflow bypass the iteration.
module riscv_muldiv_iter
    import riscv_ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  step,
    input  logic                  flush,
    input  logic [XLEN-1:0]       op1,
    input  logic [XLEN-1:0]       op2,
    input  logic [EX_FUNCT_W-1:0] funct,
    output logic                  early,
    output logic                  last,
    output logic                  done,
    output logic [XLEN-1:0]       result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_dec_t           dec_in, dec_q;
    logic              s1_in, s2_in, div0_in, ovf_in;
    logic [XLEN-1:0]   abs1_in, abs2_in;

    logic [2*XLEN-1:0] acc;      // mul: {partial hi, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]   m_q;      // multiplicand / divisor magnitude
    logic [XLEN-1:0]   op1_q;    // raw op1 for the early-out results
    logic              s1_q, s2_q, div0_q, ovf_q;
    logic [CW-1:0]     cnt;
    logic              pend_q;   // early-out result becomes ready one cycle after start
    logic              done_q;

    logic [XLEN:0]     psum, trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_f, rem_f;

    // Operand decode at start
    always_comb begin
        dec_in  = md_decode(funct);
        s1_in   = dec_in.s1_signed & op1[XLEN-1];
        s2_in   = dec_in.s2_signed & op2[XLEN-1];
        abs1_in = s1_in ? -op1 : op1;
        abs2_in = s2_in ? -op2 : op2;
        div0_in = dec_in.is_div && (op2 == '0);
        ovf_in  = dec_in.is_div && dec_in.s1_signed && (op1 == XMIN) && (op2 == '1);
    end

    assign early = div0_in || ovf_in;
    assign last  = (cnt == '0);
    assign done  = done_q;

    // One shift-add or restoring-subtract step
    always_comb begin
        psum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
        trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, m_q};
    end

    // Iteration registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc    <= '0;
            m_q    <= '0;
            op1_q  <= '0;
            dec_q  <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
            pend_q <= 1'b0;
            done_q <= 1'b0;
        end else if (flush) begin
            pend_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            acc    <= {{XLEN{1'b0}}, abs1_in};
            m_q    <= abs2_in;
            op1_q  <= op1;
            dec_q  <= dec_in;
            s1_q   <= s1_in;
            s2_q   <= s2_in;
            div0_q <= div0_in;
            ovf_q  <= ovf_in;
            cnt    <= CW'(XLEN-1);
            pend_q <= early;
            done_q <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            if (pend_q || (step && last))
                done_q <= 1'b1;
            if (step) begin
                cnt <= cnt - 1'b1;
                if (!dec_q.is_div)
                    acc <= {psum, acc[XLEN-1:1]};
                else if (!trial[XLEN])
                    acc <= {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                else
                    acc <= {acc[2*XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign restoration and special-case results
    always_comb begin
        prod  = (s1_q ^ s2_q) ? -acc : acc;
        quo_f = (s1_q ^ s2_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_f = s1_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (div0_q) begin
            quo_f = '1;
            rem_f = op1_q;
        end else if (ovf_q) begin
            quo_f = op1_q;
            rem_f = '0;
        end
        if (dec_q.is_div)
            result = dec_q.rem ? rem_f : quo_f;
        else
            result = dec_q.hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

endmodule

// File: rtl/riscv_ex_md.sv
// Execute stage: single-cycle ALU plus iterative M-extension unit behind a
// rdy/ack handshake with a registered result.
module riscv_ex_md
    import riscv_ex_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EN_MULDIV = 1'b1,
    localparam int SHW      = $clog2(XLEN)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_ex_rdy,
    output logic                  id_ex_ack,
    input  logic [XLEN-1:0]       id_ex_op1,
    input  logic [XLEN-1:0]       id_ex_op2,
    input  logic [EX_FUNCT_W-1:0] id_ex_funct,
    input  logic                  ex_flush,
    output logic                  ex_busy,
    output logic                  ex_mem_rdy,
    input  logic                  ex_mem_ack,
    output logic [XLEN-1:0]       ex_mem_data
);

    ex_state_t       state;
    logic            out_free, accept, is_md;
    logic            md_start, md_step, md_early, md_last, md_done;
    logic [XLEN-1:0] md_res, alu_res;
    logic [SHW-1:0]  shamt;

    assign out_free  = !ex_mem_rdy || ex_mem_ack;
    assign id_ex_ack = (state == EX_IDLE) && out_free && !ex_flush;
    assign accept    = id_ex_rdy && id_ex_ack;
    assign is_md     = EN_MULDIV && ex_is_muldiv(id_ex_funct);
    assign md_start  = accept && is_md;
    assign md_step   = (state == EX_BUSY) && !ex_flush;
    assign ex_busy   = (state != EX_IDLE);
    assign shamt     = id_ex_op2[SHW-1:0];

    // Single-cycle ALU; M functs land in the default when the unit is absent
    always_comb begin
        alu_res = '0;
        case (id_ex_funct)
            EX_ADD:  alu_res = id_ex_op1 + id_ex_op2;
            EX_SUB:  alu_res = id_ex_op1 - id_ex_op2;
            EX_OR:   alu_res = id_ex_op1 | id_ex_op2;
            EX_XOR:  alu_res = id_ex_op1 ^ id_ex_op2;
            EX_AND:  alu_res = id_ex_op1 & id_ex_op2;
            EX_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(id_ex_op1) < $signed(id_ex_op2)};
            EX_SLTU: alu_res = {{(XLEN-1){1'b0}}, id_ex_op1 < id_ex_op2};
            EX_SLL:  alu_res = id_ex_op1 << shamt;
            EX_SRL:  alu_res = id_ex_op1 >> shamt;
            EX_SRA:  alu_res = $unsigned($signed(id_ex_op1) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    riscv_muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .rstn   (rstn),
        .start  (md_start),
        .step   (md_step),
        .flush  (ex_flush),
        .op1    (id_ex_op1),
        .op2    (id_ex_op2),
        .funct  (id_ex_funct),
        .early  (md_early),
        .last   (md_last),
        .done   (md_done),
        .result (md_res)
    );

    // Mul/div sequencing: iterate in BUSY, wait for the output slot in DONE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= EX_IDLE;
        end else begin
            case (state)
                EX_IDLE: if (md_start) state <= md_early ? EX_DONE : EX_BUSY;
                EX_BUSY: begin
                    if (ex_flush)     state <= EX_IDLE;
                    else if (md_last) state <= EX_DONE;
                end
                EX_DONE: begin
                    if (ex_flush)                 state <= EX_IDLE;
                    else if (md_done && out_free) state <= EX_IDLE;
                end
                default: state <= EX_IDLE;
            endcase
        end
    end

    // Result register: load on ALU accept or mul/div completion, drop on ack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_mem_rdy  <= 1'b0;
            ex_mem_data <= '0;
        end else if (accept && !is_md) begin
            ex_mem_rdy  <= 1'b1;
            ex_mem_data <= alu_res;
        end else if ((state == EX_DONE) && !ex_flush && md_done && out_free) begin
            ex_mem_rdy  <= 1'b1;
            ex_mem_data <= md_res;
        end else if (ex_mem_ack) begin
            ex_mem_rdy  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_ex_md.sv
// Directed bench for riscv_ex_md (XLEN=32, M-extension enabled).
module tb_riscv_ex_md;
    import riscv_ex_pkg::*;

    logic        clk;
    logic        rstn;
    logic        id_ex_rdy;
    logic        id_ex_ack;
    logic [31:0] id_ex_op1;
    logic [31:0] id_ex_op2;
    logic [4:0]  id_ex_funct;
    logic        ex_flush;
    logic        ex_busy;
    logic        ex_mem_rdy;
    logic        ex_mem_ack;
    logic [31:0] ex_mem_data;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_ex_md #(.XLEN(32), .EN_MULDIV(1'b1)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_ex_rdy   (id_ex_rdy),
        .id_ex_ack   (id_ex_ack),
        .id_ex_op1   (id_ex_op1),
        .id_ex_op2   (id_ex_op2),
        .id_ex_funct (id_ex_funct),
        .ex_flush    (ex_flush),
        .ex_busy     (ex_busy),
        .ex_mem_rdy  (ex_mem_rdy),
        .ex_mem_ack  (ex_mem_ack),
        .ex_mem_data (ex_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        id_ex_rdy   = 1'b1;
        id_ex_funct = f;
        id_ex_op1   = a;
        id_ex_op2   = b;
    endtask

    // Single-cycle op: result valid one edge after accept
    task automatic alu_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        ex_mem_ack = 1'b1;
        present(f, a, b);
        #1;
        chk({tag, "_ack"}, id_ex_ack, 1);
        step();
        id_ex_rdy = 1'b0;
        chk({tag, "_rdy"}, ex_mem_rdy, 1);
        chk({tag, "_data"}, ex_mem_data, exp);
    endtask

    // Multi-cycle op: count edges from accept until ex_mem_rdy rises
    task automatic md_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int k;
        ex_mem_ack = 1'b1;
        present(f, a, b);
        #1;
        chk({tag, "_ack"}, id_ex_ack, 1);
        step();
        id_ex_rdy = 1'b0;
        k = 1;
        chk({tag, "_busy"}, ex_busy, 1);
        chk({tag, "_noack"}, id_ex_ack, 0);
        while (!ex_mem_rdy && k < 100) begin
            step();
            if (!ex_mem_rdy) k++;
        end
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_data"}, ex_mem_data, exp);
    endtask

    initial begin
        int seen;
        rstn        = 1'b0;
        id_ex_rdy   = 1'b0;
        id_ex_op1   = '0;
        id_ex_op2   = '0;
        id_ex_funct = EX_ADD;
        ex_flush    = 1'b0;
        ex_mem_ack  = 1'b0;
        #3;
        chk("rst_rdy",  ex_mem_rdy, 0);
        chk("rst_data", ex_mem_data, 0);
        chk("rst_busy", ex_busy, 0);
        repeat (2) step();
        rstn = 1'b1;
        step();

        // ADD then backpressure
        alu_op("add", EX_ADD, 32'd5, 32'd7, 32'd12);
        ex_mem_ack = 1'b0;
        present(EX_SUB, 32'd10, 32'd3);
        #1;
        chk("bp_ack0", id_ex_ack, 0);
        step();
        chk("bp_hold_rdy", ex_mem_rdy, 1);
        chk("bp_hold_data", ex_mem_data, 32'd12);
        chk("bp_ack1", id_ex_ack, 0);
        ex_mem_ack = 1'b1;
        #1;
        chk("bp_ack_rel", id_ex_ack, 1);
        step();
        id_ex_rdy = 1'b0;
        chk("sub_data", ex_mem_data, 32'd7);

        alu_op("sra",  EX_SRA,  32'h8000_0000, 32'h24, 32'hF800_0000);
        alu_op("sltu", EX_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1);
        alu_op("slt",  EX_SLT,  32'd1, 32'hFFFF_FFFF, 32'd0);
        alu_op("xor",  EX_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
        alu_op("sll",  EX_SLL,  32'h0000_0003, 32'd31, 32'h8000_0000);

        md_op("mul",    EX_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        md_op("mulhu",  EX_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        md_op("mulh",   EX_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        md_op("mulhsu", EX_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        md_op("div",    EX_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        md_op("rem",    EX_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        md_op("divu",   EX_DIVU,   32'd100, 32'd7, 32'd14, 33);
        md_op("remu",   EX_REMU,   32'd100, 32'd7, 32'd2, 33);
        md_op("divu0",  EX_DIVU,   32'd10, 32'd0, 32'hFFFF_FFFF, 2);
        md_op("remu0",  EX_REMU,   32'd10, 32'd0, 32'd10, 2);
        md_op("divovf", EX_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        md_op("removf", EX_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

        // Flush a divide mid-iteration
        ex_mem_ack = 1'b1;
        present(EX_DIV, 32'd1000, 32'd3);
        step();
        id_ex_rdy = 1'b0;
        repeat (9) step();
        chk("fl_busy_pre", ex_busy, 1);
        ex_flush = 1'b1;
        #1;
        chk("fl_noack", id_ex_ack, 0);
        step();
        ex_flush = 1'b0;
        chk("fl_busy", ex_busy, 0);
        chk("fl_rdy", ex_mem_rdy, 0);
        seen = 0;
        repeat (40) begin
            step();
            if (ex_mem_rdy) seen++;
        end
        chk("fl_no_result", seen, 0);
        alu_op("fl_add", EX_ADD, 32'd3, 32'd4, 32'd7);

        // Reset in the middle of a multiply
        ex_mem_ack = 1'b0;
        step();
        chk("pre_rst_data", ex_mem_data, 32'd7);
        ex_mem_ack = 1'b1;
        present(EX_MUL, 32'd6, 32'd9);
        step();
        id_ex_rdy = 1'b0;
        repeat (5) step();
        rstn = 1'b0;
        #1;
        chk("mr_rdy",  ex_mem_rdy, 0);
        chk("mr_data", ex_mem_data, 0);
        chk("mr_busy", ex_busy, 0);
        step();
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            step();
            if (ex_mem_rdy) seen++;
        end
        chk("mr_no_result", seen, 0);
        alu_op("mr_and", EX_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_ex_md.md
Name: riscv_ex_md

Overview:
Parametrised execute stage for the RISC-V pipeline. It contains a single-cycle integer ALU, the RV32I/RV64I ALU subset, and an iterative M-extension multiply/divide unit. It sits between decode and memory stages and uses the pipeline rdy/ack handshake on both sides. A registered output and a small FSM serialise multi-cycle ops and handle backpressure and flush.

Parameters:
XLEN, 32, datapath width (32 or 64)
EN_MULDIV, 1, 1 = M-extension functs execute; 0 = they complete in 1 cycle with result 0
SHW, $clog2(XLEN), shift-amount width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset; asynchronous, active-low
id_ex_rdy  input  1  decode presents valid op
id_ex_ack  output  1  EX accepts op this cycle (combinational)
id_ex_op1  input  XLEN  operand 1
id_ex_op2  input  XLEN  operand 2
id_ex_funct  input  EX_FUNCT_W  operation select
ex_flush  input  1  synchronous abort of in-flight mul/div
ex_busy  output  1  mul/div in progress (state != IDLE)
ex_mem_rdy  output  1  result valid
ex_mem_ack  input  1  memory stage takes result
ex_mem_data  output  XLEN  result

Behaviour:
- Reset (async, rstn low): state=IDLE, ex_mem_rdy=0, ex_mem_data=0, ex_busy=0, counter/accumulators=0. Reset mid-op discards the op with no output.
- out_free = !ex_mem_rdy || ex_mem_ack. An accept is id_ex_rdy && id_ex_ack.
- id_ex_ack = (state==IDLE) && out_free && !ex_flush.
- ALU functs: ADD, SUB, OR, XOR, AND, SLT (signed), SLTU, SLL, SRL, SRA. Shift amount = op2[SHW-1:0]. SLT/SLTU result is zero-extended 0/1. Undefined funct gives 0.
- ALU path: on accept, ex_mem_data<=result and ex_mem_rdy<=1 at the same edge (latency 1). In IDLE with out_free and no accept, ex_mem_rdy<=0.
- Output register holds value while ex_mem_rdy && !ex_mem_ack.
- M functs: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- FSM states: IDLE, BUSY, DONE.
  - IDLE->BUSY on accept of an M op. Latch |op1|, |op2| per signedness, sign flags and funct. Load cnt=XLEN-1.
  - IDLE->DONE directly for the early-out cases: divide by zero, or signed overflow (DIV/REM of -2^(XLEN-1) by -1).
- BUSY: one step per clock.
  - Multiply: shift-add into 2*XLEN accumulator.
  - Divide: restoring, one quotient bit per step.
  - cnt==0 -> DONE.
- Post-processing:
  - MUL/MULH*: negate 2*XLEN product if operand signs differ (MULHSU: op1 sign only). MUL returns low half, MULH* high half.
  - Quotient negated if s1^s2; remainder takes sign of s1.
  - Div by zero: quotient all-ones, remainder = op1.
  - Overflow: quotient = op1, remainder = 0.
- DONE: when out_free, ex_mem_data<=final result, ex_mem_rdy<=1, ->IDLE. Otherwise stay in DONE.
- Latency: accept edge E0, output valid after edge E(XLEN+1). Early-out: output valid after E2. Backpressure extends DONE.
- While state!=IDLE, ex_mem_rdy clears once the previous result is acked. No new accepts.
- ex_flush: BUSY/DONE->IDLE at the next edge, op dropped. Does not clear an already-valid ex_mem_rdy/ex_mem_data. Suppresses accept that cycle.
- ex_busy = state!=IDLE.
- EN_MULDIV=0: M functs are treated as the ALU default (0, latency 1), and the FSM never leaves IDLE.

Decomposition:
- Shared package riscv_ex_pkg/riscv_functions.vh: EX_FUNCT_W and all EX_* codes, including new EX_MUL..EX_REMU, plus the state encoding.
- One sub-module riscv_muldiv_iter (XLEN param; start/flush/done, operands, funct in; result out) holds the iterative datapath and counter.
- riscv_ex_md holds the ALU, handshake, FSM control and output register.

Test Plan:
- ALU ADD 5+7 with ex_mem_ack=1 -> ex_mem_data=12, ex_mem_rdy=1 one edge after accept. Then hold ex_mem_ack=0 -> data held, id_ex_ack=0 until ack.
- SRA op1=0x80000000, op2=0x24 -> 0xF8000000. SLTU 1<0xFFFFFFFF -> 1. SLT same operands -> 0.
- MUL/MULHU/MULH with 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 / 0xFFFFFFFE / 0x00000000. ex_mem_rdy rises 33 edges after accept, ex_busy high meanwhile, id_ex_ack=0.
- DIV/REM -7 by 2 -> 0xFFFFFFFD / 0xFFFFFFFF. DIVU 100/7 -> 14, REMU -> 2.
- DIVU 10/0 -> 0xFFFFFFFF; REMU 10/0 -> 10; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each valid 2 edges after accept.
- Pulse ex_flush at cycle 10 of a DIV -> IDLE next edge, no result, next ADD accepted. Separately, rstn low mid-MUL -> all outputs 0, state IDLE.
